vector_reverse_seq: RTL and testbench
=====================================

// Module: vector_reverse_seq
// PURPOSE
//  Multi-cycle bit-order reverser with valid/ready handshakes on both sides: dout[i] = din[WIDTH-1-i].
//  Turns a reversed vector back into natural order (reversal is its own inverse), or reverses a natural one.
//  Moves CHUNK bits per cycle, so a wide word costs a shift-and-count engine rather than a full-width mux layer.
//  Sits between a word producer and a consumer that may stall.
// PARAMETERS
//  WIDTH  100  word width in bits
//  CHUNK  4    bits moved per BUSY cycle; WIDTH % CHUNK == 0 is required (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  areset_n   in   1      reset, asynchronous, active-low
//  in_valid   in   1      din holds a word to be reversed
//  in_ready   out  1      block can accept a word this cycle
//  din        in   WIDTH  input word
//  abort      in   1      synchronous cancel of the word in flight
//  out_valid  out  1      dout holds a completed result
//  out_ready  in   1      consumer takes dout this cycle
//  dout       out  WIDTH  reversed word
//  busy       out  1      high in BUSY state
// BEHAVIOUR
//  Reset (areset_n=0, takes effect immediately): state=IDLE, in_ready=1, out_valid=0, busy=0,
//   dout=0, src=0, cnt=0. All of these are held until areset_n rises.
//  N = WIDTH/CHUNK (25 at default parameters); cnt is clog2(N+1) bits wide.
//  IDLE: in_ready=1. If in_valid: src<=din, cnt<=0, state<=BUSY. Otherwise stay in IDLE.
//  BUSY: in_ready=0; in_valid and din are ignored.
//   Each cycle, for j in 0..CHUNK-1 with k=cnt*CHUNK+j: dout[WIDTH-1-k] <= src[k]; then cnt<=cnt+1.
//   On the cycle with cnt==N-1 the last chunk is written and state<=DONE.
//  DONE: out_valid=1. dout is held bit-stable until the handshake.
//   If out_ready: state<=IDLE and out_valid drops on the next edge.
//   There is no IDLE bypass: the next word can be accepted no earlier than the cycle after the handshake.
//  Latency: word accepted at edge E -> out_valid=1 after edge E+N.
//   Throughput is at most 1 word per N+2 cycles.
//  dout is written only by BUSY chunks. It is not cleared on accept, and its bits are not meaningful
//   while out_valid=0.
//  abort=1: from BUSY or DONE, the next edge gives state=IDLE, out_valid=0, cnt=0, with dout unchanged.
//   abort in IDLE has no effect. abort takes priority over accept and over the output handshake in the
//   same cycle; an in_valid in that cycle is not accepted (in_ready is 0 in BUSY and DONE anyway).
//  Asynchronous reset mid-BUSY or mid-DONE discards the word; no partial output is ever flagged valid.
//  Outputs are registered or decoded from registered state only; there are no combinational paths
//   from inputs to outputs.
// TESTING
//  1 Reset: areset_n=0 mid-cycle -> in_ready=1, out_valid=0, dout=0 immediately, before any clk edge.
//  2 din=100'h1 accepted at edge E -> out_valid=1 exactly after edge E+25; dout=1<<99;
//    busy high for 25 cycles.
//  3 din=100'hF_0000_0000_0000_0000_0000_00A5 with out_ready=0 for 10 cycles -> dout stable
//    at the bit-reverse of din, out_valid held; out_ready=1 -> IDLE next cycle.
//  4 Second in_valid during BUSY with din=all-ones -> ignored; the result equals the reverse of the
//    first word.
//  5 abort at cnt=12 -> IDLE next cycle, out_valid never asserted; a new word then completes correctly.
//  6 Back-to-back: 200 random words, random out_ready -> every dout equals the combinational reversal of
//    its din. Repeat with CHUNK=1, 5, 100; with CHUNK=100, latency = 1 cycle.

Source files
------------

// File: rtl/vector_reverse_seq.sv
// Multi-cycle bit-order reverser: dout[i] = din[WIDTH-1-i], moving CHUNK bits per BUSY cycle.
// Valid/ready handshakes on both sides; abort cancels the word in flight.
module vector_reverse_seq #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_chunk_check
        $error("vector_reverse_seq: WIDTH must be a multiple of CHUNK");
    end

    localparam int N    = WIDTH / CHUNK;
    localparam int CNTW = $clog2(N + 1);
    localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] src;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] dout_nxt;

    // Each dout bit has exactly one source bit; it is loaded on the cycle its chunk index matches cnt.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        localparam logic [CNTW-1:0] CIDX = CNTW'(k / CHUNK);
        assign dout_nxt[WIDTH-1-k] = (cnt == CIDX) ? src[k] : dout[WIDTH-1-k];
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dout      <= '0;
            src       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src      <= din;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        dout <= dout_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // abort outranks the output handshake; both return to IDLE
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        if (abort) begin
                            cnt <= '0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_reverse_seq.sv
// Directed and randomized bench for vector_reverse_seq at CHUNK = 4, 1, 5 and 100 (WIDTH = 100).
// Instance 0 (CHUNK=4) carries the directed steps; all four run the random back-to-back stream.
module tb_vector_reverse_seq;

    localparam int W  = 100;
    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         areset_n;
    logic         in_valid  [NI];
    logic [W-1:0] din       [NI];
    logic         abort     [NI];
    logic         out_ready [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         busy      [NI];
    logic [W-1:0] dout      [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 5 : 100;
        vector_reverse_seq #(.WIDTH(W), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .areset_n  (areset_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .din       (din[g]),
            .abort     (abort[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .dout      (dout[g]),
            .busy      (busy[g])
        );
    end

    function automatic int chunk_of(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            2:       return 5;
            default: return 100;
        endcase
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[W-33:0], $urandom};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs == expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Present one word for one cycle; assumes the DUT is in IDLE.
    task automatic send(input int idx, input logic [W-1:0] d);
        in_valid[idx] = 1'b1;
        din[idx]      = d;
        @(negedge clk);
        in_valid[idx] = 1'b0;
    endtask

    task automatic wait_valid(input int idx, input int max, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (out_valid[idx] !== 1'b1 && lat < max) begin
            if (busy[idx] === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input int idx);
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
    endtask

    task automatic run_random(input int idx, input int nwords);
        int           n;
        int           lat;
        int           bc;
        int           g;
        logic         r;
        logic         done;
        logic [W-1:0] d;
        n = W / chunk_of(idx);
        for (int w = 0; w < nwords; w++) begin
            g = 0;
            while (in_ready[idx] !== 1'b1 && g < 10) begin
                @(negedge clk);
                g++;
            end
            chk1("rnd_in_ready", in_ready[idx], 1'b1);
            d = rnd();
            send(idx, d);
            wait_valid(idx, n + 10, lat, bc);
            chk_int("rnd_latency", lat, n);
            g    = 0;
            done = 1'b0;
            while (!done) begin
                r = (g >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                out_ready[idx] = r;
                chk("rnd_dout", dout[idx], rev(d));
                chk1("rnd_out_valid", out_valid[idx], 1'b1);
                @(negedge clk);
                if (r) done = 1'b1;
                g++;
            end
            out_ready[idx] = 1'b0;
            chk1("rnd_release", out_valid[idx], 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int           lat;
    int           bc;
    logic         seen;
    logic [W-1:0] expv;

    initial begin
        areset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            din[i]       = '0;
            abort[i]     = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk1("reset_in_ready", in_ready[0], 1'b1);
        chk1("reset_out_valid", out_valid[0], 1'b0);
        chk1("reset_busy", busy[0], 1'b0);
        chk("reset_dout", dout[0], '0);
        areset_n = 1'b1;
        @(negedge clk);

        // single set bit moves from LSB to MSB, N-cycle latency
        send(0, 100'h1);
        chk1("t2_busy", busy[0], 1'b1);
        chk1("t2_in_ready_low", in_ready[0], 1'b0);
        wait_valid(0, 40, lat, bc);
        chk_int("t2_latency", lat, 25);
        chk_int("t2_busy_cycles", bc, 25);
        expv = '0;
        expv[99] = 1'b1;
        chk("t2_dout", dout[0], expv);
        handshake(0);
        chk1("t2_in_ready_back", in_ready[0], 1'b1);
        chk1("t2_out_valid_drop", out_valid[0], 1'b0);

        // consumer stall: result held bit-stable
        send(0, 100'hF_0000_0000_0000_0000_0000_00A5);
        wait_valid(0, 40, lat, bc);
        chk_int("t3_latency", lat, 25);
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_dout", dout[0], 100'hA_5000_0000_0000_0000_0000_000F);
            chk1("t3_hold_valid", out_valid[0], 1'b1);
            chk1("t3_done_in_ready", in_ready[0], 1'b0);
            @(negedge clk);
        end
        handshake(0);
        chk1("t3_idle_in_ready", in_ready[0], 1'b1);
        chk1("t3_idle_out_valid", out_valid[0], 1'b0);
        chk1("t3_idle_busy", busy[0], 1'b0);

        // second word offered during BUSY/DONE is ignored
        send(0, 100'h3);
        in_valid[0] = 1'b1;
        din[0]      = '1;
        wait_valid(0, 40, lat, bc);
        in_valid[0] = 1'b0;
        chk_int("t4_latency", lat, 25);
        chk("t4_dout", dout[0], 100'hC_0000_0000_0000_0000_0000_0000);
        handshake(0);
        chk1("t4_not_accepted", busy[0], 1'b0);
        chk1("t4_in_ready", in_ready[0], 1'b1);

        // abort at cnt == 12
        send(0, 100'hD_EADB_EEF0_1234_5678_9ABC_DEF0);
        repeat (12) @(negedge clk);
        chk1("t5_busy_pre_abort", busy[0], 1'b1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk1("t5_abort_in_ready", in_ready[0], 1'b1);
        chk1("t5_abort_busy", busy[0], 1'b0);
        seen = 1'b0;
        repeat (30) begin
            if (out_valid[0] !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk1("t5_never_valid", seen, 1'b0);
        send(0, 100'h5);
        wait_valid(0, 40, lat, bc);
        chk_int("t5_new_latency", lat, 25);
        chk("t5_new_dout", dout[0], 100'hA_0000_0000_0000_0000_0000_0000);
        handshake(0);

        // abort in DONE beats the handshake and leaves dout untouched
        send(0, 100'h1);
        wait_valid(0, 40, lat, bc);
        abort[0]     = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        abort[0]     = 1'b0;
        out_ready[0] = 1'b0;
        chk1("abort_done_out_valid", out_valid[0], 1'b0);
        chk1("abort_done_in_ready", in_ready[0], 1'b1);
        chk("abort_done_dout_kept", dout[0], expv);

        // abort in IDLE is inert: the word is still accepted
        abort[0]    = 1'b1;
        in_valid[0] = 1'b1;
        din[0]      = 100'h2;
        @(negedge clk);
        abort[0]    = 1'b0;
        in_valid[0] = 1'b0;
        chk1("abort_idle_accept", busy[0], 1'b1);
        wait_valid(0, 40, lat, bc);
        chk("abort_idle_dout", dout[0], 100'h4_0000_0000_0000_0000_0000_0000);
        handshake(0);

        // asynchronous reset mid-BUSY, checked before any clock edge
        send(0, 100'h1);
        repeat (3) @(negedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        chk1("t1_async_in_ready", in_ready[0], 1'b1);
        chk1("t1_async_out_valid", out_valid[0], 1'b0);
        chk1("t1_async_busy", busy[0], 1'b0);
        chk("t1_async_dout", dout[0], '0);
        @(negedge clk);
        areset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            if (out_valid[0] !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk1("t1_no_partial_valid", seen, 1'b0);

        for (int i = 0; i < NI; i++) run_random(i, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
